// File: rtl/input_debouncer_if.sv
// Signal bundle between a raw-input source and input_debouncer.
// The master drives the raw line and enable; the slave (the debouncer)
// returns the conditioned level, edge pulses, busy flag and glitch count.
interface input_debouncer_if #(
    parameter int GLITCH_W = 8
) ();
    logic                Raw_In;
    logic                Enable;
    logic                Clean_Out;
    logic                Rise_Pulse;
    logic                Fall_Pulse;
    logic                Busy;
    logic [GLITCH_W-1:0] Glitch_Count;

    modport master (
        output Raw_In,
        output Enable,
        input  Clean_Out,
        input  Rise_Pulse,
        input  Fall_Pulse,
        input  Busy,
        input  Glitch_Count
    );

    modport slave (
        input  Raw_In,
        input  Enable,
        output Clean_Out,
        output Rise_Pulse,
        output Fall_Pulse,
        output Busy,
        output Glitch_Count
    );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a counter-based stability filter.
// A new synchronized level is accepted only after holding for STABLE_CYCLES
// consecutive enabled clocks; bounces that fall back early are counted as
// glitches in a saturating counter. All outputs are registered.
module input_debouncer #(
    parameter int STABLE_CYCLES = 8,
    parameter int GLITCH_W      = 8
) (
    input logic              Clk,
    input logic              Reset,
    input_debouncer_if.slave bus
);
    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {IDLE, QUALIFY} state_t;

    state_t              state, state_nxt;
    logic                sync1, sync2;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                clean, clean_nxt;
    logic                rise, rise_nxt;
    logic                fall, fall_nxt;
    logic [GLITCH_W-1:0] glitch, glitch_nxt;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + GLITCH_W'(1);
    endfunction

    // Two-stage synchronizer for the asynchronous raw input, never gated.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.Raw_In;
            sync2 <= sync1;
        end
    end

    // Qualification FSM: next state, counter, accepted level, pulses, glitches.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        clean_nxt  = clean;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        glitch_nxt = glitch;

        if (!bus.Enable) begin
            // Freezing wins over everything, including a completing qualification.
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (sync2 != clean) begin
                        if (STABLE_CYCLES == 1) begin
                            clean_nxt = sync2;
                            rise_nxt  = sync2;
                            fall_nxt  = ~sync2;
                        end else begin
                            cnt_nxt   = CNT_ONE;
                            state_nxt = QUALIFY;
                        end
                    end
                end
                QUALIFY: begin
                    if (sync2 == clean) begin
                        // Bounced back before holding long enough.
                        cnt_nxt    = '0;
                        state_nxt  = IDLE;
                        glitch_nxt = sat_inc(glitch);
                    end else if (cnt == CNT_LAST) begin
                        clean_nxt = sync2;
                        rise_nxt  = sync2;
                        fall_nxt  = ~sync2;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // State and output registers; reset forces everything quiet at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            clean  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            clean  <= clean_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            glitch <= glitch_nxt;
        end
    end

    assign bus.Clean_Out    = clean;
    assign bus.Rise_Pulse   = rise;
    assign bus.Fall_Pulse   = fall;
    assign bus.Busy         = (state == QUALIFY);
    assign bus.Glitch_Count = glitch;
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: three instances (STABLE_CYCLES 4/4/1, the second
// with a 2-bit glitch counter) share one raw/enable stimulus. A window-based
// reference model predicts every output.
module tb_input_debouncer;
    localparam int NDUT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic raw   = 1'b0;
    logic en    = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    input_debouncer_if #(.GLITCH_W(8)) if4 ();
    input_debouncer_if #(.GLITCH_W(2)) ifg ();
    input_debouncer_if #(.GLITCH_W(8)) if1 ();

    assign if4.Raw_In = raw;
    assign if4.Enable = en;
    assign ifg.Raw_In = raw;
    assign ifg.Enable = en;
    assign if1.Raw_In = raw;
    assign if1.Enable = en;

    input_debouncer #(.STABLE_CYCLES(4), .GLITCH_W(8)) dut4 (.Clk(clk), .Reset(rst_n), .bus(if4.slave));
    input_debouncer #(.STABLE_CYCLES(4), .GLITCH_W(2)) dutg (.Clk(clk), .Reset(rst_n), .bus(ifg.slave));
    input_debouncer #(.STABLE_CYCLES(1), .GLITCH_W(8)) dut1 (.Clk(clk), .Reset(rst_n), .bus(if1.slave));

    // {clean, rise, fall, busy, glitch[7:0]}
    logic [11:0] obs [NDUT];
    assign obs[0] = {if4.Clean_Out, if4.Rise_Pulse, if4.Fall_Pulse, if4.Busy, if4.Glitch_Count};
    assign obs[1] = {ifg.Clean_Out, ifg.Rise_Pulse, ifg.Fall_Pulse, ifg.Busy, 6'd0, ifg.Glitch_Count};
    assign obs[2] = {if1.Clean_Out, if1.Rise_Pulse, if1.Fall_Pulse, if1.Busy, if1.Glitch_Count};

    // Reference model: a new level is accepted when the last N synchronized
    // samples all differ from the current level and were all enabled.
    int   ncyc [NDUT] = '{4, 4, 1};
    int   gmax [NDUT] = '{255, 3, 255};
    logic m_s1, m_s2;
    logic h_en [$];
    logic h_s2 [$];
    logic m_clean [NDUT];
    logic m_rise  [NDUT];
    logic m_fall  [NDUT];
    logic m_busy  [NDUT];
    int   m_glitch[NDUT];

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        h_en.delete();
        h_s2.delete();
        for (int d = 0; d < NDUT; d++) begin
            m_clean[d]  = 1'b0;
            m_rise[d]   = 1'b0;
            m_fall[d]   = 1'b0;
            m_busy[d]   = 1'b0;
            m_glitch[d] = 0;
        end
    endtask

    task automatic model_step();
        int n;
        h_en.push_back(en);
        h_s2.push_back(m_s2);
        if (h_en.size() > 16) begin
            h_en.delete(0);
            h_s2.delete(0);
        end
        n = h_en.size();
        for (int d = 0; d < NDUT; d++) begin
            logic acc;
            logic gl;
            acc = (n >= ncyc[d]);
            if (acc) begin
                for (int j = 0; j < ncyc[d]; j++) begin
                    if (!h_en[n-1-j] || (h_s2[n-1-j] == m_clean[d])) acc = 1'b0;
                end
            end
            // Abort: the previous enabled sample differed without being
            // accepted, and this enabled sample matches the level again.
            gl = (n >= 2) && h_en[n-1] && (h_s2[n-1] == m_clean[d])
                 && h_en[n-2] && (h_s2[n-2] != m_clean[d]);
            m_rise[d] = acc && m_s2;
            m_fall[d] = acc && !m_s2;
            if (acc) m_clean[d] = m_s2;
            if (gl && (m_glitch[d] < gmax[d])) m_glitch[d] = m_glitch[d] + 1;
            m_busy[d] = en && (m_s2 != m_clean[d]);
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    function automatic logic [11:0] exp_vec(input int d);
        return {m_clean[d], m_rise[d], m_fall[d], m_busy[d], 8'(m_glitch[d])};
    endfunction

    // Advance one clock: model follows the rising edge, return on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        raw = 1'b0;
        en  = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        for (int d = 0; d < NDUT; d++) begin
            n_tests++;
            if (obs[d] !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_init dut%0d: got %h expected 000", d, obs[d]);
            end
        end
        rst_n = 1'b1;
        raw   = 1'b1;
        repeat (4) tick();
        n_tests++;
        if (if4.Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_reset: got %b expected 1", if4.Busy);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < NDUT; d++) begin
            n_tests++;
            if (obs[d] !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_async dut%0d: got %h expected 000", d, obs[d]);
            end
        end
        raw = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int d = 0; d < NDUT; d++) begin
                n_tests++;
                if (obs[d] !== 12'h000) begin
                    n_fail++;
                    $display("FAIL post_reset_quiet dut%0d cyc %0d: got %h expected 000", d, c, obs[d]);
                end
            end
        end
    endtask

    task automatic test_clean_rise();
        raw = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            n_tests++;
            if ({if4.Busy, if4.Clean_Out, if4.Rise_Pulse} !== {(j >= 3 && j <= 5), (j >= 6), (j == 6)}) begin
                n_fail++;
                $display("FAIL clean_rise sc4 j=%0d: busy/clean/rise got %b%b%b", j, if4.Busy, if4.Clean_Out, if4.Rise_Pulse);
            end
            n_tests++;
            if ({if1.Busy, if1.Clean_Out, if1.Rise_Pulse} !== {1'b0, (j >= 3), (j == 3)}) begin
                n_fail++;
                $display("FAIL clean_rise sc1 j=%0d: busy/clean/rise got %b%b%b", j, if1.Busy, if1.Clean_Out, if1.Rise_Pulse);
            end
        end
    endtask

    task automatic test_stable1();
        raw = 1'b0;
        repeat (8) tick();
        raw = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            if (j == 1) raw = 1'b0;
            n_tests++;
            if ({if1.Busy, if1.Clean_Out, if1.Rise_Pulse, if1.Fall_Pulse} !== {1'b0, (j == 3), (j == 3), (j == 4)}) begin
                n_fail++;
                $display("FAIL stable1 sc1 j=%0d: busy/clean/rise/fall got %b%b%b%b", j,
                         if1.Busy, if1.Clean_Out, if1.Rise_Pulse, if1.Fall_Pulse);
            end
            n_tests++;
            if ({if4.Clean_Out, if4.Busy, if4.Glitch_Count} !== {1'b0, (j == 3), 8'((j >= 4) ? 1 : 0)}) begin
                n_fail++;
                $display("FAIL stable1 sc4 j=%0d: clean/busy got %b%b glitch %0d", j, if4.Clean_Out, if4.Busy, if4.Glitch_Count);
            end
        end
    endtask

    task automatic test_bounce();
        int g0;
        int rises;
        g0    = m_glitch[0];
        rises = 0;
        for (int j = 1; j <= 14; j++) begin
            raw = (j <= 3) || (j >= 6);
            tick();
            if (if4.Rise_Pulse === 1'b1) rises++;
            n_tests++;
            if ({if4.Clean_Out, if4.Glitch_Count} !== {(j >= 11), 8'(g0 + ((j >= 6) ? 1 : 0))}) begin
                n_fail++;
                $display("FAIL bounce j=%0d: clean %b glitch %0d, expected clean %b glitch %0d", j,
                         if4.Clean_Out, if4.Glitch_Count, (j >= 11), g0 + ((j >= 6) ? 1 : 0));
            end
        end
        n_tests++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL bounce_rise_count: got %0d expected 1", rises);
        end
    endtask

    task automatic test_enable_freeze();
        int g0;
        g0  = m_glitch[0];
        en  = 1'b0;
        raw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_tests++;
            if ({if4.Clean_Out, if4.Fall_Pulse, if4.Busy, if4.Glitch_Count, if1.Clean_Out} !== {3'b100, 8'(g0), 1'b1}) begin
                n_fail++;
                $display("FAIL freeze cyc %0d: clean/fall/busy %b%b%b glitch %0d sc1 clean %b", c,
                         if4.Clean_Out, if4.Fall_Pulse, if4.Busy, if4.Glitch_Count, if1.Clean_Out);
            end
        end
        en = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            n_tests++;
            if ({if4.Clean_Out, if4.Fall_Pulse, if1.Fall_Pulse} !== {(j < 4), (j == 4), (j == 1)}) begin
                n_fail++;
                $display("FAIL unfreeze j=%0d: sc4 clean/fall %b%b sc1 fall %b", j, if4.Clean_Out, if4.Fall_Pulse, if1.Fall_Pulse);
            end
        end
        // Enable dropping on the completing edge must block the change.
        raw = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            en = (j != 6);
            tick();
            n_tests++;
            if ({if4.Clean_Out, if4.Rise_Pulse, if4.Busy, if4.Glitch_Count} !==
                {(j >= 10), (j == 10), ((j >= 3 && j <= 5) || (j >= 7 && j <= 9)), 8'(g0)}) begin
                n_fail++;
                $display("FAIL enable_wins j=%0d: clean/rise/busy %b%b%b glitch %0d", j,
                         if4.Clean_Out, if4.Rise_Pulse, if4.Busy, if4.Glitch_Count);
            end
        end
    endtask

    task automatic test_glitch_sat();
        int exp_g [5] = '{1, 2, 3, 3, 3};
        raw = 1'b0;
        en  = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            raw = 1'b1;
            repeat (2) tick();
            raw = 1'b0;
            repeat (4) tick();
            n_tests++;
            if ({ifg.Clean_Out, 6'd0, ifg.Glitch_Count} !== {1'b0, 8'(exp_g[i])}) begin
                n_fail++;
                $display("FAIL glitch_sat bounce %0d: clean %b count %0d expected %0d", i, ifg.Clean_Out, ifg.Glitch_Count, exp_g[i]);
            end
            n_tests++;
            if (if4.Glitch_Count !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL glitch_wide bounce %0d: got %0d expected %0d", i, if4.Glitch_Count, i + 1);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                if ($urandom_range(0, 3) != 0) raw = ~raw;
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            en = ($urandom_range(0, 15) != 0);
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                model_reset();
            end
            tick();
            for (int d = 0; d < NDUT; d++) begin
                n_tests++;
                if (obs[d] !== exp_vec(d)) begin
                    n_fail++;
                    $display("FAIL random dut%0d cyc %0d: got %h expected %h", d, c, obs[d], exp_vec(d));
                end
                n_tests++;
                if (obs[d][10:9] == 2'b11) begin
                    n_fail++;
                    $display("FAIL pulse_exclusive dut%0d cyc %0d: rise/fall got 11 expected not both", d, c);
                end
            end
            if (c == 1500) rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_stable1();
        test_bounce();
        test_enable_freeze();
        test_glitch_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions one raw, asynchronous input (push-button, switch, or off-board line) into a clean, glitch-free level that is safe to drive the D input of the downstream registered flip-flop stage. The input is passed through a two-stage synchronizer, then through a counter-based stability filter. The filter accepts a new level only after it has held for a programmable number of consecutive clocks. One-cycle rise and fall pulses and a saturating glitch counter are also produced for use by downstream logic.

## Interface
- STABLE_CYCLES, default 8: consecutive clocks a new synchronized level must hold before `Clean_Out` accepts it; legal range 1..65535.
- GLITCH_W, default 8: width of the glitch counter.
- Clk  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-low reset (asserted when 0), synchronously released by the system.
- Raw_In  input  1  unsynchronized raw input.
- Enable  input  1  filter enable; when 0, filtering is frozen (see Operation).
- Clean_Out  output  1  debounced level; feeds the downstream flip-flop D input.
- Rise_Pulse  output  1  one-cycle pulse on each accepted 0→1 change of `Clean_Out`.
- Fall_Pulse  output  1  one-cycle pulse on each accepted 1→0 change of `Clean_Out`.
- Busy  output  1  high while a candidate level is being qualified.
- Glitch_Count  output  GLITCH_W  number of aborted qualifications; saturates at all-ones.

## Operation
- Synchronizer: `sync1 <= Raw_In`, `sync2 <= sync1` every clock, regardless of `Enable`. Only `sync2` is used downstream.
- Counter width: `$clog2(STABLE_CYCLES+1)` bits, unsigned. It counts 0..STABLE_CYCLES-1 and never wraps.
- The FSM has two states, IDLE and QUALIFY. `Busy` = (state == QUALIFY).
- IDLE, `sync2 == Clean_Out`: stay in IDLE with count = 0.
- IDLE, `sync2 != Clean_Out`, Enable = 1, STABLE_CYCLES = 1: update `Clean_Out` and pulse immediately; stay in IDLE.
- IDLE, `sync2 != Clean_Out`, Enable = 1, STABLE_CYCLES > 1: count <= 1, go to QUALIFY.
- QUALIFY, `sync2 != Clean_Out`, count == STABLE_CYCLES-1: `Clean_Out <= sync2`, assert the matching pulse, count <= 0, go to IDLE.
- QUALIFY, `sync2 != Clean_Out`, count < STABLE_CYCLES-1: count++.
- QUALIFY, `sync2 == Clean_Out` (bounce back): abort. Count <= 0, go to IDLE, `Glitch_Count` increments unless it is already saturated.
- Enable = 0, from any state: go to IDLE, count <= 0. `Clean_Out` and `Glitch_Count` hold, no pulses are produced, and an abort caused by deassertion is not counted as a glitch.
- Pulses are registered and asserted for exactly the single cycle in which `Clean_Out` first shows its new value. `Rise_Pulse` and `Fall_Pulse` are never high together.

## Timing
- Reset values: `sync1` = `sync2` = 0, `Clean_Out` = 0, `Rise_Pulse` = `Fall_Pulse` = 0, `Busy` = 0, `Glitch_Count` = 0, count = 0, state IDLE.
- Reset is asynchronous: all outputs reach their reset values immediately on assertion, mid-qualification included. No pulse is emitted on assertion or on release.
- Latency: if `Raw_In` is first sampled at rising edge k and then held, `sync2` changes after edge k+1, and `Clean_Out` and its pulse change after edge k+1+STABLE_CYCLES.
- A bounce shorter than STABLE_CYCLES clocks at `sync2` never reaches `Clean_Out`. Pulses of `Raw_In` shorter than one clock may be missed entirely by design.
- Simultaneous events:
  - Enable falling on the same edge that qualification would complete: Enable wins, and `Clean_Out` does not change.
  - Abort with `Glitch_Count` at all-ones: return to IDLE; the counter stays at all-ones.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench runs with STABLE_CYCLES = 4 unless stated.
- Reset check: assert Reset = 0 mid-run while Busy = 1. Required response: all outputs 0 immediately. After release with `Raw_In` = 0, outputs stay 0 and no pulses appear.
- Clean rise: `Raw_In` goes 0→1 sampled at edge 10 and is held. Required response: `Busy` high after edge 12; `Clean_Out` = 1 and `Rise_Pulse` high for one cycle after edge 15; `Busy` low after edge 15.
- Bounce rejection: `Raw_In` high for 3 clocks, low for 2, then high and held. Required response: `Glitch_Count` = 1; `Clean_Out` rises exactly 5 edges after the final rising sample, i.e. STABLE_CYCLES+1; one `Rise_Pulse` in total.
- Enable freeze: a held 1→0 change with Enable = 0 produces no `Clean_Out` change and no pulse; `Glitch_Count` is unchanged. Raising Enable starts qualification, and `Fall_Pulse` appears 4 clocks later.
- Glitch saturation: with GLITCH_W = 2, apply 5 aborted bounces. Required response: `Glitch_Count` reads 1, 2, 3, 3, 3.
- STABLE_CYCLES = 1: `Raw_In` 0→1 sampled at edge k gives `Clean_Out` = 1 and `Rise_Pulse` after edge k+2; `Busy` is never asserted.
